// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Optional macro MDU_DIV0_FLAG_EN: divide-by-zero short-cut with div0 flag.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             skip_nx;

  // Operand conditioning at accept time
  logic             sgn_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign sgn_in = ~op[0];
  assign a_neg  = sgn_in & a[WIDTH-1];
  assign b_neg  = sgn_in & b[WIDTH-1];
  assign abs_a  = a_neg ? -a : a;
  assign abs_b  = b_neg ? -b : b;

`ifdef MDU_DIV0_FLAG_EN
  logic skip_q;
  logic div0_q;
  assign skip_nx = op[1] & (b == '0);
  assign div0    = div0_q;
`else
  assign skip_nx = 1'b0;
`endif

  // One shift-add (multiply) or restoring (divide) iteration
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
    rsh     = {acc_hi, acc_lo[WIDTH-1]};
    diff    = rsh - {1'b0, mag};
    ge      = rsh >= {1'b0, mag};
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (op_q[1]) begin
      step_hi = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ge};
    end
  end

  // Sign fix-up of the magnitude result
  logic             sgn_q;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    sgn_q  = ~op_q[0];
    prod   = {acc_hi, acc_lo};
    prod_s = (sgn_q & (neg_a ^ neg_b)) ? -prod : prod;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (op_q[1]) begin
      res_hi = (sgn_q & neg_a) ? -acc_hi : acc_hi;
      res_lo = (sgn_q & (neg_a ^ neg_b)) ? -acc_lo : acc_lo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: IDLE -> CALC -> FIX -> IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = skip_nx ? FIX : CALC;
      CALC:    if (cnt == CNT_LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath, HI/LO and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MDU_DIV0_FLAG_EN
      skip_q <= 1'b0;
      div0_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            neg_a  <= a_neg;
            neg_b  <= b_neg;
            mag    <= op[1] ? abs_b : abs_a;
            acc_lo <= op[1] ? abs_a : abs_b;
            acc_hi <= '0;
            cnt    <= '0;
`ifdef MDU_DIV0_FLAG_EN
            skip_q <= skip_nx;
            div0_q <= 1'b0;
`endif
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        CALC: begin
          cnt    <= cnt + 1'b1;
          acc_hi <= step_hi;
          acc_lo <= step_lo;
        end
        FIX: begin
          done_q <= 1'b1;
`ifdef MDU_DIV0_FLAG_EN
          if (skip_q) begin
            div0_q <= 1'b1;
          end else begin
            hi <= res_hi;
            lo <= res_lo;
          end
`else
          hi <= res_hi;
          lo <= res_lo;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: architectural model plus literal checks.
// Honours MDU_DIV0_FLAG_EN in the same way as the design.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
`ifdef MDU_DIV0_FLAG_EN
  logic          div0;
`endif

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MDU_DIV0_FLAG_EN
    ,
    .div0  (div0)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      fails++;
      if (fails < 40)
        $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: HI/LO, remaining busy cycles, done, div0
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_div0 = 1'b0;
  logic [W-1:0] p_hi;
  logic [W-1:0] p_lo;
  logic         p_skip;
  longint       sa;
  longint       sb;
  longint       pr;
  logic [63:0]  up;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_div0 = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          if (p_skip) begin
            m_div0 = 1'b1;
          end else begin
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (start) begin
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        p_skip = 1'b0;
        m_div0 = 1'b0;
        m_cnt  = W + 1;
        case (op)
          2'b00: begin
            pr   = sa * sb;
            p_hi = pr[63:32];
            p_lo = pr[31:0];
          end
          2'b01: begin
            up   = {32'b0, a} * {32'b0, b};
            p_hi = up[63:32];
            p_lo = up[31:0];
          end
          default: begin
            if (b == 0) begin
              p_hi = a;
              p_lo = (op == 2'b10 && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
`ifdef MDU_DIV0_FLAG_EN
              p_skip = 1'b1;
              m_cnt  = 1;
`endif
            end else if (op == 2'b10) begin
              pr   = sa / sb;
              p_lo = pr[31:0];
              pr   = sa % sb;
              p_hi = pr[31:0];
            end else begin
              p_lo = a / b;
              p_hi = a % b;
            end
          end
        endcase
      end else begin
        if (mthi) m_hi = wdata;
        if (mtlo) m_lo = wdata;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_cnt > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
`ifdef MDU_DIV0_FLAG_EN
      chk("div0", 64'(div0), 64'(m_div0));
`endif
    end
  end

  // Issue one op and return in its done cycle (time = edge + 1)
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic with_mthi,
                        input logic mid_mtlo, output int bcnt);
    int n;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (with_mthi) begin
      mthi  = 1'b1;
      wdata = 32'h0000_DEAD;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    bcnt  = 0;
    n     = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      if (mid_mtlo && n == 5) begin
        mtlo  = 1'b1;
        wdata = 32'h0000_BEEF;
      end else begin
        mtlo = 1'b0;
      end
      n++;
      @(posedge clk);
      #1;
    end
    mtlo = 1'b0;
    if (n >= 40) chk("done_timeout", 64'(n), 64'd0);
  endtask

  logic [1:0]   t_op[8];
  logic [W-1:0] t_a[8];
  logic [W-1:0] t_b[8];

  initial begin
    int bc;
    t_op = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    t_a  = '{32'h8000_0000, 32'hFFFF_FFF9, 32'h1234_5678, 32'd7,
             32'hFFFF_FFF9, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd5};
    t_b  = '{32'h8000_0000, 32'hFFFF_FFFA, 32'h9ABC_DEF0, 32'hFFFF_FFFE,
             32'hFFFF_FFFE, 32'd1000, 32'd1, 32'd9};

    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, bc);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    chk("mult_done", 64'(done), 64'd1);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, bc);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);
    chk("multu_busy_cycles", 64'(bc), 64'd33);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, bc);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, bc);
    chk("divu_b2b_lo", 64'(lo), 64'd14);
    chk("divu_b2b_hi", 64'(hi), 64'd2);

    @(posedge clk);
    #1;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    chk("mtlo", 64'(lo), 64'h1234);

    run_op(2'b00, 32'd6, 32'd7, 1'b1, 1'b0, bc);
    chk("start_mthi_hi", 64'(hi), 64'd0);
    chk("start_mthi_lo", 64'(lo), 64'd42);

    run_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b1, bc);
    chk("busy_mtlo_lo", 64'(lo), 64'd12);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, bc);
    chk("ovf_lo", 64'(lo), 64'h8000_0000);
    chk("ovf_hi", 64'(hi), 64'd0);

    op    = 2'b10;
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    run_op(2'b11, 32'd1000, 32'd3, 1'b0, 1'b0, bc);
    chk("after_abort_lo", 64'(lo), 64'd333);
    chk("after_abort_hi", 64'(hi), 64'd1);

    run_op(2'b11, 32'd9, 32'd0, 1'b0, 1'b0, bc);
`ifdef MDU_DIV0_FLAG_EN
    chk("divu0_busy_cycles", 64'(bc), 64'd1);
    chk("divu0_flag", 64'(div0), 64'd1);
    chk("divu0_lo", 64'(lo), 64'd333);
    chk("divu0_hi", 64'(hi), 64'd1);
`else
    chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("divu0_hi", 64'(hi), 64'd9);
`endif

    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, bc);
`ifdef MDU_DIV0_FLAG_EN
    chk("div0_lo", 64'(lo), 64'd333);
`else
    chk("div0_lo", 64'(lo), 64'd1);
    chk("div0_hi", 64'(hi), 64'hFFFF_FFFB);
`endif

    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0, bc);
    end
    chk("tbl_divu_5_9_lo", 64'(lo), 64'd0);
    chk("tbl_divu_5_9_hi", 64'(hi), 64'd5);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
